// File: rtl/fetch_unit_if.sv
// Fetch-side bus bundle: imem request/response channels, redirect input and decode output.
interface fetch_unit_if #(
  parameter int XLEN = 32
);
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_resp_valid;
  logic [XLEN-1:0] imem_resp_data;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_insn;
  logic [XLEN-1:0] out_pc;

  // master is the fetch unit's view of the bundle
  modport master (
    output imem_req_valid, imem_req_addr, out_valid, out_insn, out_pc,
    input  imem_req_ready, imem_resp_valid, imem_resp_data,
           redirect_valid, redirect_pc, out_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, out_valid, out_insn, out_pc,
    output imem_req_ready, imem_resp_valid, imem_resp_data,
           redirect_valid, redirect_pc, out_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Fetch stage: issues word-addressed PCs to imem, queues in-order responses for decode.
// Redirect clears the queue and arms a drop counter for responses already in flight.
module fetch_unit #(
  parameter int              XLEN            = 32,
  parameter int              QUEUE_DEPTH     = 4,
  parameter int              MAX_OUTSTANDING = 2,
  parameter logic [XLEN-1:0] RESET_PC        = '0
) (
  input logic          clk,
  input logic          rst,
  fetch_unit_if.master bus
);
  localparam int QW = $clog2(QUEUE_DEPTH);
  localparam int CW = QW + 1;
  localparam int AW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int IW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [IW-1:0] MAX_OS  = IW'(MAX_OUTSTANDING);
  localparam logic [AW-1:0] AF_LAST = AW'(MAX_OUTSTANDING - 1);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] insn;
  } fq_entry_t;

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] af_mem_q [MAX_OUTSTANDING];
  logic [AW-1:0]   af_wr_q, af_wr_d, af_rd_q, af_rd_d;
  logic [IW-1:0]   inflight_q, inflight_d, drop_q, drop_d;
  fq_entry_t       fq_mem_q [QUEUE_DEPTH];
  logic [QW-1:0]   head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;
  logic [31:0]     credit_used;
  logic            redirect, req_fire, resp_fire, q_push, q_pop;

  assign redirect  = bus.redirect_valid;
  assign resp_fire = bus.imem_resp_valid;

  // Live responses (inflight minus those already marked stale) each own a queue slot.
  assign credit_used = 32'(count_q) + 32'(inflight_q) - 32'(drop_q);

  assign bus.imem_req_valid = !rst && !redirect && (inflight_q < MAX_OS) &&
                              (credit_used < 32'(QUEUE_DEPTH));
  assign bus.imem_req_addr  = fetch_pc_q;
  assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;

  assign q_push        = resp_fire && !redirect && (drop_q == '0);
  assign bus.out_valid = !rst && !redirect && (count_q != '0);
  assign q_pop         = bus.out_valid && bus.out_ready;
  assign bus.out_pc    = fq_mem_q[head_q].pc;
  assign bus.out_insn  = fq_mem_q[head_q].insn;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    af_wr_d    = af_wr_q;
    af_rd_d    = af_rd_q;
    drop_d     = drop_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    inflight_d = inflight_q + IW'(req_fire) - IW'(resp_fire);

    if (req_fire) begin
      fetch_pc_d = fetch_pc_q + 1'b1;
      af_wr_d    = (af_wr_q == AF_LAST) ? '0 : af_wr_q + 1'b1;
    end
    // Every response consumes its address, even when it is discarded.
    if (resp_fire) begin
      af_rd_d = (af_rd_q == AF_LAST) ? '0 : af_rd_q + 1'b1;
    end

    if (redirect) begin
      fetch_pc_d = bus.redirect_pc;
      drop_d     = inflight_q - IW'(resp_fire);
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
    end else begin
      if (resp_fire && (drop_q != '0)) begin
        drop_d = drop_q - 1'b1;
      end
      if (q_push) begin
        tail_d = tail_q + 1'b1;
      end
      if (q_pop) begin
        head_d = head_q + 1'b1;
      end
      count_d = count_q + CW'(q_push) - CW'(q_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      af_wr_q    <= '0;
      af_rd_q    <= '0;
      inflight_q <= '0;
      drop_q     <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      af_wr_q    <= af_wr_d;
      af_rd_q    <= af_rd_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
    end
  end

  // Storage needs no reset: validity is tracked entirely by the pointers and counters.
  always_ff @(posedge clk) begin
    if (req_fire) begin
      af_mem_q[af_wr_q] <= fetch_pc_q;
    end
    if (q_push) begin
      fq_mem_q[tail_q] <= '{pc: af_mem_q[af_rd_q], insn: bus.imem_resp_data};
    end
  end

  a_resp_without_request: assert property (
    @(posedge clk) disable iff (rst) !(resp_fire && (inflight_q == '0)));

  a_queue_overflow: assert property (
    @(posedge clk) disable iff (rst) !(q_push && !q_pop && (count_q == CW'(QUEUE_DEPTH))));
endmodule
